// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared FSM state type and sweep-order constants
package truth_table_sweeper_pkg;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int GRAY_OFF = 0;
    localparam int GRAY_ON  = 1;
    localparam int HOLD_W   = 4;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control, stimulus and result signals of one sweeper
interface truth_table_sweeper_if #(parameter int N_IN = 3);

    logic            start;
    logic            abort;
    logic            dut_y;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_vld;

    modport master (
        output start, abort, dut_y,
        input  dut_in, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );

    modport slave (
        input  start, abort, dut_y,
        output dut_in, busy, done, pass, err_cnt, first_fail, first_fail_vld
    );

endinterface

// File: rtl/truth_table_sweeper_bin2gray.sv
// bin2gray: combinational binary index to reflected Gray code map
module bin2gray #(parameter int W = 3) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive self-running checker of a 1-output combinational function
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                    N_IN   = 3,
    parameter logic [2**N_IN-1:0]    EXP_TT = 8'hE8,
    parameter int                    SETTLE = 0,
    parameter int                    GRAY   = GRAY_OFF
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam logic [N_IN-1:0] LAST = '1;

    state_t              state, state_d;
    logic [N_IN-1:0]     idx, idx_inc, gray_inc, vec_nxt, dut_in, first_fail;
    logic [HOLD_W-1:0]   hold;
    logic [N_IN:0]       err_cnt;
    logic                busy, done, pass, first_fail_vld;
    logic                accept, quit, sample, fin, mismatch;

    assign idx_inc = idx + N_IN'(1);

    bin2gray #(.W(N_IN)) u_bin2gray (.bin(idx_inc), .gray(gray_inc));

    assign vec_nxt = (GRAY == GRAY_ON) ? gray_inc : idx_inc;

    // Decode the current edge's action; abort in RUN outranks a coinciding sample
    always_comb begin
        accept   = (state == S_IDLE) && bus.start;
        quit     = (state == S_RUN) && bus.abort;
        sample   = (state == S_RUN) && !bus.abort && (hold == '0);
        fin      = sample && (idx == LAST);
        mismatch = bus.dut_y != EXP_TT[dut_in];
        state_d  = accept ? S_RUN : (quit || fin) ? S_IDLE : state;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Sweep datapath: index/hold counters, stimulus and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            hold           <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                idx            <= '0;
                hold           <= HOLD_W'(SETTLE);
                dut_in         <= '0;
                busy           <= 1'b1;
                err_cnt        <= '0;
                first_fail_vld <= 1'b0;
                pass           <= 1'b0;
            end else if (quit) begin
                busy <= 1'b0;
                pass <= 1'b0;
            end else if (state == S_RUN && !sample) begin
                hold <= hold - HOLD_W'(1);
            end else if (sample) begin
                err_cnt <= err_cnt + (N_IN + 1)'(mismatch);
                if (mismatch && !first_fail_vld) begin
                    first_fail     <= dut_in;
                    first_fail_vld <= 1'b1;
                end
                if (fin) begin
                    busy <= 1'b0;
                    pass <= (err_cnt == '0) && !mismatch;
                end else begin
                    idx    <= idx_inc;
                    dut_in <= vec_nxt;
                    hold   <= HOLD_W'(SETTLE);
                end
            end
        end
    end

    assign bus.dut_in         = dut_in;
    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.err_cnt        = err_cnt;
    assign bus.first_fail     = first_fail;
    assign bus.first_fail_vld = first_fail_vld;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of binary and Gray sweeps, abort and reset
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
        end \
    end

module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   fails  = 0;
    int   mode   = 0;
    logic [2:0] gseq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(3)) b1 ();
    truth_table_sweeper_if #(.N_IN(3)) b2 ();

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    assign b1.dut_y = (mode == 2) ? 1'b0 : maj(b1.dut_in) ^ ((mode == 1) && (b1.dut_in == 3'd5));
    assign b2.dut_y = maj(b2.dut_in);

    truth_table_sweeper #(.N_IN(3), .EXP_TT(8'hE8), .SETTLE(0), .GRAY(0)) u_bin (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave)
    );

    truth_table_sweeper #(.N_IN(3), .EXP_TT(8'hE8), .SETTLE(2), .GRAY(1)) u_gray (
        .clk(clk), .rst_n(rst_n), .bus(b2.slave)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2000) @(posedge clk);
        checks++;
        fails++;
        $error("FAIL timeout: test sequence did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    task automatic run1(input logic with_abort, input logic pulse_mid, input int e_err,
                        input int e_ff, input logic e_vld, input logic e_pass);
        b1.start = 1'b1;
        b1.abort = with_abort;
        @(negedge clk);
        b1.start = 1'b0;
        b1.abort = 1'b0;
        for (int k = 0; k < 8; k++) begin
            `CHK("busy_run", b1.busy, 1'b1)
            `CHK("dut_in_bin", b1.dut_in, 3'(k))
            `CHK("done_early", b1.done, 1'b0)
            b1.start = pulse_mid && (k == 3);
            @(negedge clk);
        end
        b1.start = 1'b0;
        `CHK("busy_end", b1.busy, 1'b0)
        `CHK("done_pulse", b1.done, 1'b1)
        `CHK("pass", b1.pass, e_pass)
        `CHK("err_cnt", b1.err_cnt, 4'(e_err))
        `CHK("first_fail_vld", b1.first_fail_vld, e_vld)
        if (e_vld) `CHK("first_fail", b1.first_fail, 3'(e_ff))
        @(negedge clk);
        `CHK("done_one_cycle", b1.done, 1'b0)
        `CHK("pass_held", b1.pass, e_pass)
    endtask

    initial begin
        rst_n = 1'b0;
        b1.start = 1'b0; b1.abort = 1'b0;
        b2.start = 1'b0; b2.abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_pass", b1.pass, 0);
        chk("rst_err", b1.err_cnt, 0);
        chk("rst_vld", b1.first_fail_vld, 0);
        chk("rst_dut_in", b1.dut_in, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mode = 0;
        run1(1'b0, 1'b1, 0, 0, 1'b0, 1'b1);
        mode = 1;
        run1(1'b0, 1'b0, 1, 5, 1'b1, 1'b0);
        mode = 2;
        run1(1'b1, 1'b0, 4, 3, 1'b1, 1'b0);

        b2.start = 1'b1;
        @(negedge clk);
        b2.start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            `CHK("gray_busy", b2.busy, 1'b1)
            `CHK("gray_dut_in", b2.dut_in, gseq[i / 3])
            @(negedge clk);
        end
        `CHK("gray_busy_end", b2.busy, 1'b0)
        `CHK("gray_done", b2.done, 1'b1)
        `CHK("gray_pass", b2.pass, 1'b1)
        `CHK("gray_err", b2.err_cnt, 4'd0)

        mode = 0;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        repeat (3) @(negedge clk);
        `CHK("abort_busy_before", b1.busy, 1'b1)
        b1.abort = 1'b1;
        @(negedge clk);
        b1.abort = 1'b0;
        `CHK("abort_busy", b1.busy, 1'b0)
        `CHK("abort_pass", b1.pass, 1'b0)
        `CHK("abort_err", b1.err_cnt, 4'd0)
        `CHK("abort_dut_in", b1.dut_in, 3'd3)
        for (int i = 0; i < 4; i++) begin
            `CHK("abort_no_done", b1.done, 1'b0)
            @(negedge clk);
        end
        `CHK("abort_idle_busy", b1.busy, 1'b0)

        mode = 1;
        b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        `CHK("midrst_busy", b1.busy, 1'b0)
        `CHK("midrst_dut_in", b1.dut_in, 3'd0)
        `CHK("midrst_err", b1.err_cnt, 4'd0)
        `CHK("midrst_done", b1.done, 1'b0)
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run1(1'b0, 1'b0, 1, 5, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
